// File: rtl/ay8913_mixer.sv
// ay8913_mixer
//   Channel mixer and volume stage. On sample_tick the tone/noise bits, mixer
//   enables, per-channel amplitudes and envelope level are snapshotted. The
//   three gated channels then go through a logarithmic volume table and are
//   summed one per cycle. The sum is held on value for the PDM DAC.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   sample_tick    single-cycle request to start a mix
//   tone[2:0]      tone outputs, bit0=A bit1=B bit2=C
//   noise          shared noise output
//   tone_disable   1 = tone disabled for that channel
//   noise_disable  1 = noise disabled for that channel
//   amp_a/b/c      bit4 = envelope mode, bits3:0 = fixed level
//   envelope       current envelope level
//   value          mixed level, left-aligned to OUT_BITS, held between mixes
//   value_valid    one-cycle pulse when value updates
//   busy           high while a mix is in progress
//   overrun        one-cycle pulse when sample_tick arrives while busy
//
// State | meaning
//   IDLE | waiting for sample_tick
//   CH_A | add channel A contribution
//   CH_B | add channel B contribution
//   CH_C | add channel C contribution
//   DONE | publish accumulator to value, pulse value_valid
module ay8913_mixer #(
  parameter int OUT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_tick,
  input  logic [2:0]          tone,
  input  logic                noise,
  input  logic [2:0]          tone_disable,
  input  logic [2:0]          noise_disable,
  input  logic [4:0]          amp_a,
  input  logic [4:0]          amp_b,
  input  logic [4:0]          amp_c,
  input  logic [3:0]          envelope,
  output logic [OUT_BITS-1:0] value,
  output logic                value_valid,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CH_A = 3'd1,
    CH_B = 3'd2,
    CH_C = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t     state;
  logic [2:0] tone_q;
  logic       noise_q;
  logic [2:0] tone_dis_q;
  logic [2:0] noise_dis_q;
  logic [4:0] amp_a_q;
  logic [4:0] amp_b_q;
  logic [4:0] amp_c_q;
  logic [3:0] env_q;
  logic [7:0] acc;

  logic [1:0] ch_idx;
  logic [4:0] ch_amp;
  logic       ch_gate;
  logic [3:0] ch_level;
  logic [7:0] ch_vol;

  function automatic logic [7:0] vol_lut(input logic [3:0] lvl);
    logic [7:0] v;
    case (lvl)
      4'd0:  v = 8'd0;
      4'd1:  v = 8'd1;
      4'd2:  v = 8'd1;
      4'd3:  v = 8'd1;
      4'd4:  v = 8'd2;
      4'd5:  v = 8'd3;
      4'd6:  v = 8'd4;
      4'd7:  v = 8'd5;
      4'd8:  v = 8'd8;
      4'd9:  v = 8'd11;
      4'd10: v = 8'd15;
      4'd11: v = 8'd21;
      4'd12: v = 8'd30;
      4'd13: v = 8'd42;
      4'd14: v = 8'd60;
      default: v = 8'd85;
    endcase
    return v;
  endfunction

  // Contribution of the channel selected by the current state.
  always_comb begin
    ch_idx = 2'd0;
    ch_amp = amp_a_q;
    case (state)
      CH_B: begin ch_idx = 2'd1; ch_amp = amp_b_q; end
      CH_C: begin ch_idx = 2'd2; ch_amp = amp_c_q; end
      default: begin ch_idx = 2'd0; ch_amp = amp_a_q; end
    endcase
    // Both sources disabled leaves the gate stuck high, as on the real chip.
    ch_gate  = (tone_q[ch_idx] | tone_dis_q[ch_idx]) & (noise_q | noise_dis_q[ch_idx]);
    ch_level = ch_amp[4] ? env_q : ch_amp[3:0];
    ch_vol   = ch_gate ? vol_lut(ch_level) : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tone_q      <= '0;
      noise_q     <= 1'b0;
      tone_dis_q  <= '0;
      noise_dis_q <= '0;
      amp_a_q     <= '0;
      amp_b_q     <= '0;
      amp_c_q     <= '0;
      env_q       <= '0;
      acc         <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      overrun     <= (state != IDLE) && sample_tick;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            tone_q      <= tone;
            noise_q     <= noise;
            tone_dis_q  <= tone_disable;
            noise_dis_q <= noise_disable;
            amp_a_q     <= amp_a;
            amp_b_q     <= amp_b;
            amp_c_q     <= amp_c;
            env_q       <= envelope;
            acc         <= '0;
            busy        <= 1'b1;
            state       <= CH_A;
          end
        end
        // Max sum is 3*85 = 255, so the 8-bit add cannot overflow.
        CH_A: begin
          acc   <= acc + ch_vol;
          state <= CH_B;
        end
        CH_B: begin
          acc   <= acc + ch_vol;
          state <= CH_C;
        end
        CH_C: begin
          acc   <= acc + ch_vol;
          state <= DONE;
        end
        DONE: begin
          value       <= OUT_BITS'(acc) << (OUT_BITS - 8);
          value_valid <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ay8913_mixer.sv
module tb_ay8913_mixer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic [2:0] tone = '0;
  logic       noise = 1'b0;
  logic [2:0] tone_disable = '0;
  logic [2:0] noise_disable = '0;
  logic [4:0] amp_a = '0;
  logic [4:0] amp_b = '0;
  logic [4:0] amp_c = '0;
  logic [3:0] envelope = '0;

  logic [7:0] value8;
  logic       valid8, busy8, overrun8;
  logic [9:0] value10;
  logic       valid10, busy10, overrun10;

  always #5 clk = ~clk;

  ay8913_mixer #(.OUT_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .tone(tone), .noise(noise), .tone_disable(tone_disable),
    .noise_disable(noise_disable), .amp_a(amp_a), .amp_b(amp_b),
    .amp_c(amp_c), .envelope(envelope),
    .value(value8), .value_valid(valid8), .busy(busy8), .overrun(overrun8)
  );

  ay8913_mixer #(.OUT_BITS(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .tone(tone), .noise(noise), .tone_disable(tone_disable),
    .noise_disable(noise_disable), .amp_a(amp_a), .amp_b(amp_b),
    .amp_c(amp_c), .envelope(envelope),
    .value(value10), .value_valid(valid10), .busy(busy10), .overrun(overrun10)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_valid = 0;

  typedef struct { int exp; int tick_cyc; } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_mix();
    int tbl [16] = '{0,1,1,1,2,3,4,5,8,11,15,21,30,42,60,85};
    logic [4:0] a [3];
    int s = 0;
    a[0] = amp_a; a[1] = amp_b; a[2] = amp_c;
    for (int i = 0; i < 3; i++) begin
      int lvl;
      bit g;
      g = (tone[i] | tone_disable[i]) & (noise | noise_disable[i]);
      lvl = a[i][4] ? int'(envelope) : int'(a[i][3:0]);
      if (g) s += tbl[lvl];
    end
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && valid8) begin
      exp_t e;
      n_valid++;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("value8", int'(value8), e.exp);
        chk("latency", cyc - e.tick_cyc, 4);
        chk("valid10", int'(valid10), 1);
        chk("value10", int'(value10), e.exp * 4);
      end
    end
  end

  // Drive a tick at a negedge; the next posedge is the tick edge.
  task automatic tick_push(input int exp);
    exp_t e;
    e.exp = exp;
    e.tick_cyc = cyc + 1;
    sb.push_back(e);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic mix(input int exp);
    tick_push(exp);
    repeat (6) @(negedge clk);
  endtask

  task automatic set_all(input logic [2:0] t, input logic n, input logic [2:0] td,
                         input logic [2:0] nd, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [3:0] env);
    tone = t; noise = n; tone_disable = td; noise_disable = nd;
    amp_a = a; amp_b = b; amp_c = c; envelope = env;
  endtask

  initial begin
    int vcount;
    repeat (3) @(negedge clk);
    chk("rst_value", int'(value8), 0);
    chk("rst_valid", int'(valid8), 0);
    chk("rst_busy", int'(busy8), 0);
    chk("rst_overrun", int'(overrun8), 0);
    rst_n = 1'b1;
    @(negedge clk);

    set_all(3'b111, 1'b1, 3'b000, 3'b000, 5'h0F, 5'h0F, 5'h0F, 4'd0);
    mix(255);

    set_all(3'b111, 1'b1, 3'b000, 3'b000, 5'h1F, 5'h08, 5'h00, 4'd12);
    mix(38);

    set_all(3'b110, 1'b1, 3'b000, 3'b000, 5'h0F, 5'h0F, 5'h0F, 4'd0);
    mix(170);
    tone_disable = 3'b001;
    mix(255);
    noise = 1'b0; noise_disable = 3'b011;
    mix(170);

    // Snapshot: change amp_b right after the tick edge.
    set_all(3'b111, 1'b1, 3'b000, 3'b000, 5'h0F, 5'h0F, 5'h0F, 4'd0);
    tick_push(255);
    amp_b = 5'h00;
    repeat (6) @(negedge clk);
    mix(170);

    // Overrun: second tick two cycles after the first.
    amp_b = 5'h0F;
    vcount = n_valid;
    tick_push(255);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("overrun_pulse", int'(overrun8), 1);
    chk("busy_mid", int'(busy8), 1);
    @(negedge clk);
    chk("overrun_clear", int'(overrun8), 0);
    @(negedge clk);
    chk("valid_at_4", int'(valid8), 1);
    chk("busy_after_done", int'(busy8), 0);
    repeat (6) @(negedge clk);
    chk("overrun_valid_count", n_valid - vcount, 1);

    // Async reset during CH_B; previous value is 255.
    chk("pre_reset_value", int'(value8), 255);
    vcount = n_valid;
    tick_push(170);
    amp_b = 5'h00;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_value", int'(value8), 0);
    chk("async_busy", int'(busy8), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_valid_after_abort", n_valid - vcount, 0);
    mix(170);

    // Random mixes against the reference model.
    for (int k = 0; k < 12; k++) begin
      set_all(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      mix(ref_mix());
    end

    repeat (4) @(negedge clk);
    chk("pending_results", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
